// File: rtl/ir_fetch_ctrl_pkg.sv
// Shared rob_processor definitions for the instruction-register path:
// instruction width and the fetch sequencer state encoding.
package ir_fetch_ctrl_pkg;

  localparam int INSTR_W = 18;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_ISSUE = 3'd2,
    ST_VALID = 3'd3,
    ST_EXEC  = 3'd4,
    ST_FAULT = 3'd5
  } fetch_state_e;

  function automatic logic state_is_busy(input fetch_state_e s);
    return (s != ST_IDLE) && (s != ST_FAULT);
  endfunction

endpackage

// File: rtl/fetch_watchdog.sv
// Fetch watchdog: counts FETCH cycles without a memory ack and flags expiry
// in the cycle the count reaches TIMEOUT. TIMEOUT=0 disables it entirely.
module fetch_watchdog #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  generate
    if (TIMEOUT == 0) begin : g_off
      logic unused_inputs;
      assign unused_inputs = ^{clk, rst, clear, enable};
      assign expired       = 1'b0;
    end else begin : g_on
      localparam logic [CNT_W-1:0] MAX  = CNT_W'(TIMEOUT);
      localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

      logic [CNT_W-1:0] count_q;
      logic [CNT_W-1:0] count_d;

      always_comb begin
        count_d = count_q;
        if (clear) begin
          count_d = '0;
        end else if (enable && (count_q != MAX)) begin
          count_d = count_q + 1'b1;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          count_q <= '0;
        end else begin
          count_q <= count_d;
        end
      end

      // Expiry is combinational so the owner can leave FETCH on this same edge.
      assign expired = enable && !clear && (count_q == LAST);
    end
  endgenerate

endmodule

// File: rtl/ir_fetch_ctrl.sv
// Instruction-register fetch sequencer: fetch, write IR, read IR for one
// decode cycle, wait for execute, then advance or redirect the PC.
module ir_fetch_ctrl
  import ir_fetch_ctrl_pkg::*;
#(
  parameter int                ADDR_W   = 10,
  parameter logic [ADDR_W-1:0] PC_RESET = '0,
  parameter int                TIMEOUT  = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              halt_req,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  output logic              wr_IR,
  output logic              re_IR,
  output logic              ir_valid,
  input  logic              ex_done,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              fault
);

  fetch_state_e      state_q;
  fetch_state_e      state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;
  logic              wd_clear;
  logic              wd_enable;
  logic              wd_expired;

  // Holding the count cleared outside FETCH guarantees a fresh count on each entry.
  assign wd_clear = (state_q != ST_FETCH);

  fetch_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    mem_req   = 1'b0;
    wr_IR     = 1'b0;
    re_IR     = 1'b0;
    ir_valid  = 1'b0;
    fault     = 1'b0;
    wd_enable = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          wr_IR   = 1'b1;
          state_d = ST_ISSUE;
        end else begin
          wd_enable = 1'b1;
          if (wd_expired) begin
            state_d = ST_FAULT;
          end
        end
      end
      ST_ISSUE: begin
        re_IR   = 1'b1;
        state_d = ST_VALID;
      end
      ST_VALID: begin
        ir_valid = 1'b1;
        state_d  = ST_EXEC;
      end
      ST_EXEC: begin
        if (ex_done) begin
          pc_d    = br_taken ? br_target : pc_q + 1'b1;
          state_d = halt_req ? ST_IDLE : ST_FETCH;
        end
      end
      ST_FAULT: begin
        fault = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= PC_RESET;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign pc       = pc_q;
  assign mem_addr = pc_q;
  assign busy     = state_is_busy(state_q);

endmodule

// File: tb/tb_ir_fetch_ctrl.sv
// Directed bench for ir_fetch_ctrl: instruction timing, branch/wrap,
// halt/resume, watchdog expiry and late ack, asynchronous reset.
module tb_ir_fetch_ctrl;

  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              halt_req = 1'b0;
  logic              mem_ack = 1'b0;
  logic              ex_done = 1'b0;
  logic              br_taken = 1'b0;
  logic [ADDR_W-1:0] br_target = '0;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              wr_IR;
  logic              re_IR;
  logic              ir_valid;
  logic [ADDR_W-1:0] pc;
  logic              busy;
  logic              fault;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ir_fetch_ctrl #(
    .ADDR_W   (ADDR_W),
    .PC_RESET (10'h000),
    .TIMEOUT  (15)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .halt_req  (halt_req),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .wr_IR     (wr_IR),
    .re_IR     (re_IR),
    .ir_valid  (ir_valid),
    .ex_done   (ex_done),
    .br_taken  (br_taken),
    .br_target (br_target),
    .pc        (pc),
    .busy      (busy),
    .fault     (fault)
  );

  task automatic applyStimulus(input logic s, input logic h, input logic a,
                               input logic e, input logic b,
                               input logic [ADDR_W-1:0] t);
    start     = s;
    halt_req  = h;
    mem_ack   = a;
    ex_done   = e;
    br_taken  = b;
    br_target = t;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkStrobes(input string tag, input logic eReq, input logic eWr,
                              input logic eRe, input logic eVal, input logic eBusy,
                              input logic eFault, input logic [ADDR_W-1:0] ePc);
    checkOutput({tag, ".mem_req"},  32'(mem_req),  32'(eReq));
    checkOutput({tag, ".wr_IR"},    32'(wr_IR),    32'(eWr));
    checkOutput({tag, ".re_IR"},    32'(re_IR),    32'(eRe));
    checkOutput({tag, ".ir_valid"}, 32'(ir_valid), 32'(eVal));
    checkOutput({tag, ".busy"},     32'(busy),     32'(eBusy));
    checkOutput({tag, ".fault"},    32'(fault),    32'(eFault));
    checkOutput({tag, ".pc"},       32'(pc),       32'(ePc));
    checkOutput({tag, ".mem_addr"}, 32'(mem_addr), 32'(ePc));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  // Starts at the beginning of a FETCH cycle; ends at the start of the cycle after ex_done.
  task automatic runInstr(input int waitCycles, input logic brt,
                          input logic [ADDR_W-1:0] tgt, input logic hlt,
                          input int execWait, input logic [ADDR_W-1:0] expPc);
    for (int i = 0; i < waitCycles; i++) begin
      applyStimulus(1'b0, hlt, 1'b0, 1'b0, 1'b0, '0);
      settle();
      checkStrobes("fetch_wait", 1, 0, 0, 0, 1, 0, expPc);
      tick();
    end
    applyStimulus(1'b0, hlt, 1'b1, 1'b0, 1'b0, '0);
    settle();
    checkStrobes("fetch_ack", 1, 1, 0, 0, 1, 0, expPc);
    tick();
    applyStimulus(1'b0, hlt, 1'b0, 1'b0, 1'b0, '0);
    settle();
    checkStrobes("issue", 0, 0, 1, 0, 1, 0, expPc);
    tick();
    settle();
    checkStrobes("valid", 0, 0, 0, 1, 1, 0, expPc);
    tick();
    for (int i = 0; i < execWait; i++) begin
      settle();
      checkStrobes("exec_wait", 0, 0, 0, 0, 1, 0, expPc);
      tick();
    end
    applyStimulus(1'b0, hlt, 1'b0, 1'b1, brt, tgt);
    settle();
    checkStrobes("exec_done", 0, 0, 0, 0, 1, 0, expPc);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL sim_timeout: observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

  initial begin
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    settle();
    checkStrobes("reset", 0, 0, 0, 0, 0, 0, 10'h000);
    tick();
    rst = 1'b0;

    // Minimum instruction cycle: start@0, ack@1, ex_done@4
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    settle();
    checkStrobes("c0_idle", 0, 0, 0, 0, 0, 0, 10'h000);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    settle();
    checkStrobes("c1_fetch", 1, 1, 0, 0, 1, 0, 10'h000);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    settle();
    checkStrobes("c2_issue", 0, 0, 1, 0, 1, 0, 10'h000);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 10'h155);
    settle();
    checkStrobes("c3_valid_spurious", 0, 0, 0, 1, 1, 0, 10'h000);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    settle();
    checkStrobes("c4_exec", 0, 0, 0, 0, 1, 0, 10'h000);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    settle();
    checkStrobes("c5_fetch", 1, 0, 0, 0, 1, 0, 10'h001);
    tick();

    runInstr(0, 1'b1, 10'h2A5, 1'b0, 0, 10'h001);
    settle();
    checkStrobes("branch_2a5", 1, 0, 0, 0, 1, 0, 10'h2A5);
    tick();

    runInstr(2, 1'b1, 10'h3FF, 1'b0, 1, 10'h2A5);
    settle();
    checkStrobes("branch_3ff", 1, 0, 0, 0, 1, 0, 10'h3FF);
    tick();

    runInstr(0, 1'b0, 10'h000, 1'b0, 0, 10'h3FF);
    settle();
    checkStrobes("pc_wrap", 1, 0, 0, 0, 1, 0, 10'h000);
    tick();

    runInstr(0, 1'b0, 10'h000, 1'b1, 1, 10'h000);
    settle();
    checkStrobes("halt_idle", 0, 0, 0, 0, 0, 0, 10'h001);
    tick();

    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 10'h0F0);
    settle();
    checkStrobes("idle_spurious", 0, 0, 0, 0, 0, 0, 10'h001);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    settle();
    checkStrobes("idle_start", 0, 0, 0, 0, 0, 0, 10'h001);
    tick();

    // Ack in the 15th FETCH cycle must win over the watchdog
    runInstr(14, 1'b0, 10'h000, 1'b0, 0, 10'h001);

    // No ack: FAULT exactly 15 cycles after FETCH entry
    settle();
    checkStrobes("wd_entry", 1, 0, 0, 0, 1, 0, 10'h002);
    tick();
    for (int i = 1; i < 15; i++) begin
      settle();
      checkStrobes("wd_fetch", 1, 0, 0, 0, 1, 0, 10'h002);
      tick();
    end
    settle();
    checkStrobes("wd_fault", 0, 0, 0, 0, 0, 1, 10'h002);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 10'h111);
    tick();
    settle();
    checkStrobes("fault_hold", 0, 0, 0, 0, 0, 1, 10'h002);
    tick();
    rst = 1'b1;
    #1;
    checkStrobes("fault_rst", 0, 0, 0, 0, 0, 0, 10'h000);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    tick();
    rst = 1'b0;

    // Asynchronous reset while in ISSUE
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    tick();
    runInstr(0, 1'b1, 10'h0AB, 1'b0, 0, 10'h000);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    settle();
    checkStrobes("pre_rst_fetch", 1, 1, 0, 0, 1, 0, 10'h0AB);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    settle();
    checkStrobes("pre_rst_issue", 0, 0, 1, 0, 1, 0, 10'h0AB);
    #1;
    rst = 1'b1;
    #1;
    checkStrobes("issue_async_rst", 0, 0, 0, 0, 0, 0, 10'h000);
    tick();
    rst = 1'b0;
    settle();
    checkStrobes("post_rst_idle", 0, 0, 0, 0, 0, 0, 10'h000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
